// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encoding, flag bit positions and per-mode
// writeback rules used by the issue controller.
package alu_pkg;

    typedef enum logic [3:0] {
        MODE_NOP     = 4'd0,
        MODE_MOV     = 4'd1,
        MODE_CMP     = 4'd2,
        MODE_TEST    = 4'd3,
        MODE_SHL     = 4'd4,
        MODE_SHR     = 4'd5,
        MODE_ADD     = 4'd6,
        MODE_ADC     = 4'd7,
        MODE_SUB     = 4'd8,
        MODE_SBB     = 4'd9,
        MODE_MUL     = 4'd10,
        MODE_AND     = 4'd11,
        MODE_OR      = 4'd12,
        MODE_XOR     = 4'd13,
        MODE_NOT     = 4'd14,
        MODE_ILLEGAL = 4'd15
    } alu_mode_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_S = 6;
    localparam int FLAG_C = 5;
    localparam int FLAG_V = 4;

    function automatic logic [7:0] flag_write_mask(input logic [3:0] mode);
        logic [7:0] mask;
        mask = '0;
        case (mode)
            MODE_CMP, MODE_TEST, MODE_ADD, MODE_ADC, MODE_SUB, MODE_SBB,
            MODE_AND, MODE_OR, MODE_XOR, MODE_NOT: begin
                mask[FLAG_Z] = 1'b1;
                mask[FLAG_S] = 1'b1;
                mask[FLAG_C] = 1'b1;
                mask[FLAG_V] = 1'b1;
            end
            MODE_MUL: mask[FLAG_Z] = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

    // Compare-style ops, NOP and the illegal code return zero instead of the ALU output.
    function automatic logic mode_writes_result(input logic [3:0] mode);
        logic wr;
        case (mode)
            MODE_NOP, MODE_CMP, MODE_TEST, MODE_ILLEGAL: wr = 1'b0;
            default:                                     wr = 1'b1;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last served requester
// and only moves when the grant is actually accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       owner
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign owner = grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= owner;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: arbitrates two requesters, drives
// the ALU for one cycle, captures result/flags and returns them via valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int TAG_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][3:0]           req_mode,
    input  logic [1:0][WORD_SIZE-1:0] req_a,
    input  logic [1:0][WORD_SIZE-1:0] req_b,
    input  logic [1:0][TAG_WIDTH-1:0] req_tag,
    output logic [1:0]                resp_valid,
    input  logic [1:0]                resp_ready,
    output logic [WORD_SIZE-1:0]      resp_data,
    output logic [7:0]                resp_flags,
    output logic [TAG_WIDTH-1:0]      resp_tag,
    output logic                      resp_err,
    output logic [3:0]                alu_mode,
    output logic [WORD_SIZE-1:0]      alu_a,
    output logic [WORD_SIZE-1:0]      alu_b,
    output logic                      alu_carry_in,
    input  logic [WORD_SIZE-1:0]      alu_result,
    input  logic [7:0]                alu_flags,
    output logic [7:0]                flags_q,
    input  logic                      flags_clr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_q;
    logic [3:0]           issue_mode_q;
    logic [TAG_WIDTH-1:0] issue_tag_q;
    logic                 owner_q;

    logic [1:0]           grant;
    logic                 grant_owner;
    logic                 accept;
    logic                 resp_hs;
    logic [7:0]           wmask;
    logic [7:0]           flags_next;
    logic [WORD_SIZE-1:0] data_next;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .owner  (grant_owner)
    );

    assign req_ready    = (state_q == ST_IDLE) ? grant : 2'b00;
    assign accept       = (state_q == ST_IDLE) && |(req_valid & grant);
    assign resp_valid   = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_hs      = (state_q == ST_RESP) && resp_ready[owner_q];
    assign alu_carry_in = flags_q[FLAG_C];

    // MOV returns the second operand straight from the issue register.
    always_comb begin
        wmask      = flag_write_mask(issue_mode_q);
        flags_next = (flags_q & ~wmask) | (alu_flags & wmask);
        if (issue_mode_q == MODE_MOV) begin
            data_next = alu_b;
        end else if (mode_writes_result(issue_mode_q)) begin
            data_next = alu_result;
        end else begin
            data_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            issue_mode_q <= '0;
            issue_tag_q  <= '0;
            owner_q      <= 1'b0;
            alu_mode     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            resp_data    <= '0;
            resp_flags   <= '0;
            resp_tag     <= '0;
            resp_err     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        issue_mode_q <= req_mode[grant_owner];
                        issue_tag_q  <= req_tag[grant_owner];
                        owner_q      <= grant_owner;
                        alu_mode     <= (req_mode[grant_owner] == MODE_ILLEGAL) ? 4'd0 : req_mode[grant_owner];
                        alu_a        <= req_a[grant_owner];
                        alu_b        <= req_b[grant_owner];
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_data  <= data_next;
                    resp_flags <= flags_next;
                    resp_tag   <= issue_tag_q;
                    resp_err   <= (issue_mode_q == MODE_ILLEGAL);
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_hs) begin
                        alu_mode <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The EXEC capture takes precedence over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (state_q == ST_EXEC) begin
            flags_q <= flags_next;
        end else if (flags_clr) begin
            flags_q <= '0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU stands in for the
// real one, and a transaction-level model predicts grants, results and flags.
module tb_alu_issue_ctrl;

    localparam int W  = 8;
    localparam int TW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][3:0]      req_mode;
    logic [1:0][W-1:0]    req_a;
    logic [1:0][W-1:0]    req_b;
    logic [1:0][TW-1:0]   req_tag;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [W-1:0]         resp_data;
    logic [7:0]           resp_flags;
    logic [TW-1:0]        resp_tag;
    logic                 resp_err;
    logic [3:0]           alu_mode;
    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic                 alu_carry_in;
    logic [W-1:0]         alu_result;
    logic [7:0]           alu_flags;
    logic [7:0]           flags_q;
    logic                 flags_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_flags;
    logic       model_last;
    logic [3:0] p_mode [2];
    logic [7:0] p_a    [2];
    logic [7:0] p_b    [2];
    logic [1:0] p_tag  [2];
    logic [7:0] last_data;
    logic       last_carry;

    alu_issue_ctrl #(.WORD_SIZE(W), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_flags   (resp_flags),
        .resp_tag     (resp_tag),
        .resp_err     (resp_err),
        .alu_mode     (alu_mode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_carry_in (alu_carry_in),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .flags_q      (flags_q),
        .flags_clr    (flags_clr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {Z,S,C,V,0000, result}.
    function automatic logic [15:0] alu_fn(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic cin);
        int         s;
        logic [7:0] r;
        logic       c;
        logic       v;
        r = '0; c = 1'b0; v = 1'b0;
        case (m)
            4'd1: r = b;
            4'd2, 4'd8, 4'd9: begin
                s = int'(a) - int'(b) - ((m == 4'd9) ? int'(cin) : 0);
                r = s[7:0];
                c = (s < 0);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd3, 4'd11: r = a & b;
            4'd4: r = a << b[2:0];
            4'd5: r = a >> b[2:0];
            4'd6, 4'd7: begin
                s = int'(a) + int'(b) + ((m == 4'd7) ? int'(cin) : 0);
                r = s[7:0];
                c = (s > 255);
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd10: begin
                s = int'(a) * int'(b);
                r = s[7:0];
                c = (s > 255);
                v = c;
            end
            4'd12: r = a | b;
            4'd13: r = a ^ b;
            4'd14: r = ~a;
            default: r = '0;
        endcase
        return {(r == 8'd0), r[7], c, v, 4'b0000, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_mode, alu_a, alu_b, alu_carry_in);

    function automatic logic [7:0] ref_mask(input logic [3:0] m);
        if (m inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14}) return 8'hF0;
        if (m == 4'd10) return 8'h80;
        return 8'h00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
        p_mode[r] = m; p_a[r] = a; p_b[r] = b; p_tag[r] = t;
        req_mode[r] = m; req_a[r] = a; req_b[r] = b; req_tag[r] = t;
    endtask

    // One full transaction, entered and left at posedge+1 with the DUT idle.
    task automatic issueOp(input logic [1:0] vmask, input logic [1:0] vmask_after, input int hold, input bit clr_exec);
        logic       o;
        logic [1:0] oh;
        logic [3:0] m;
        logic [3:0] meff;
        logic [7:0] a, b, mask, newf, expd;
        logic [1:0] tg;
        logic [15:0] alu;
        req_valid = vmask;
        #1;
        o  = (vmask == 2'b11) ? ~model_last : vmask[1];
        oh = o ? 2'b10 : 2'b01;
        checkOutput("req_ready_grant", req_ready, oh);
        m = p_mode[o]; a = p_a[o]; b = p_b[o]; tg = p_tag[o];
        meff = (m == 4'd15) ? 4'd0 : m;
        @(posedge clk); #1;
        req_valid = vmask_after;
        if (clr_exec) flags_clr = 1'b1;
        checkOutput("exec_alu_mode", alu_mode, meff);
        checkOutput("exec_alu_a", alu_a, a);
        checkOutput("exec_alu_b", alu_b, b);
        checkOutput("exec_carry_in", alu_carry_in, model_flags[5]);
        checkOutput("exec_resp_valid", resp_valid, 2'b00);
        checkOutput("exec_req_ready", req_ready, 2'b00);
        last_carry = alu_carry_in;
        alu  = alu_fn(meff, a, b, model_flags[5]);
        mask = ref_mask(m);
        newf = (model_flags & ~mask) | (alu[15:8] & mask);
        if (m == 4'd1) expd = b;
        else if (m inside {4'd0, 4'd2, 4'd3, 4'd15}) expd = 8'h00;
        else expd = alu[7:0];
        @(posedge clk); #1;
        flags_clr = 1'b0;
        checkOutput("resp_valid", resp_valid, oh);
        checkOutput("resp_data", resp_data, expd);
        checkOutput("resp_flags", resp_flags, newf);
        checkOutput("resp_tag", resp_tag, tg);
        checkOutput("resp_err", resp_err, (m == 4'd15));
        checkOutput("flags_q_after", flags_q, newf);
        last_data   = resp_data;
        model_flags = newf;
        model_last  = o;
        for (int i = 0; i < hold; i++) begin
            resp_ready = ~oh;
            @(posedge clk); #1;
            checkOutput("hold_resp_valid", resp_valid, oh);
            checkOutput("hold_resp_data", resp_data, expd);
            checkOutput("hold_resp_flags", resp_flags, newf);
            checkOutput("hold_resp_tag", resp_tag, tg);
            checkOutput("hold_req_ready", req_ready, 2'b00);
        end
        resp_ready = oh;
        @(posedge clk); #1;
        resp_ready = 2'b00;
        checkOutput("post_resp_valid", resp_valid, 2'b00);
        checkOutput("post_alu_mode", alu_mode, 4'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] saved_flags;
        rst = 1'b1; req_valid = '0; resp_ready = '0; flags_clr = 1'b0;
        req_mode = '0; req_a = '0; req_b = '0; req_tag = '0;
        for (int r = 0; r < 2; r++) applyStimulus(r, 4'd0, 8'd0, 8'd0, 2'd0);
        model_flags = '0; model_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", req_ready, 2'b00);
        checkOutput("rst_resp_valid", resp_valid, 2'b00);
        checkOutput("rst_resp_data", resp_data, 8'h00);
        checkOutput("rst_resp_flags", resp_flags, 8'h00);
        checkOutput("rst_resp_tag", resp_tag, 2'd0);
        checkOutput("rst_resp_err", resp_err, 1'b0);
        checkOutput("rst_flags_q", flags_q, 8'h00);
        checkOutput("rst_alu_mode", alu_mode, 4'd0);
        checkOutput("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
        rst = 1'b0;

        $display("[TB] ADD overflow from requester 0");
        applyStimulus(0, 4'd6, 8'h7F, 8'h01, 2'd2);
        issueOp(2'b01, 2'b00, 0, 1'b0);
        checkOutput("add_data_const", last_data, 8'h80);
        checkOutput("add_flags_const", flags_q, 8'h50);

        $display("[TB] both requesters continuously valid");
        applyStimulus(0, 4'd6, 8'h03, 8'h04, 2'd1);
        applyStimulus(1, 4'd11, 8'hF0, 8'h3C, 2'd3);
        for (int i = 0; i < 4; i++) issueOp(2'b11, 2'b11, 0, 1'b0);

        $display("[TB] CMP then SHL");
        applyStimulus(0, 4'd2, 8'h05, 8'h05, 2'd0);
        issueOp(2'b01, 2'b00, 0, 1'b0);
        checkOutput("cmp_data_zero", last_data, 8'h00);
        checkOutput("cmp_flag_z", flags_q[7], 1'b1);
        checkOutput("cmp_flag_c", flags_q[5], 1'b0);
        saved_flags = model_flags;
        applyStimulus(0, 4'd4, 8'h05, 8'h01, 2'd1);
        issueOp(2'b01, 2'b00, 0, 1'b0);
        checkOutput("shl_data_const", last_data, 8'h0A);
        checkOutput("shl_flags_unchanged", flags_q, saved_flags);

        $display("[TB] borrow then ADC, then illegal mode");
        applyStimulus(1, 4'd8, 8'h00, 8'h01, 2'd2);
        issueOp(2'b10, 2'b00, 0, 1'b0);
        checkOutput("sub_borrow_c", flags_q[5], 1'b1);
        applyStimulus(0, 4'd7, 8'h10, 8'h20, 2'd3);
        issueOp(2'b01, 2'b00, 0, 1'b0);
        checkOutput("adc_carry_in_const", last_carry, 1'b1);
        checkOutput("adc_data_const", last_data, 8'h31);
        saved_flags = model_flags;
        applyStimulus(1, 4'd15, 8'hAA, 8'h55, 2'd1);
        issueOp(2'b10, 2'b00, 0, 1'b0);
        checkOutput("illegal_flags_unchanged", flags_q, saved_flags);

        $display("[TB] response stall with competing requester");
        applyStimulus(0, 4'd13, 8'hC3, 8'h0F, 2'd2);
        applyStimulus(1, 4'd12, 8'h01, 8'h02, 2'd3);
        issueOp(2'b01, 2'b10, 5, 1'b0);
        checkOutput("stall_req1_ready_after", req_ready, 2'b10);
        issueOp(2'b10, 2'b00, 0, 1'b0);

        $display("[TB] flags_clr in idle and during capture");
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        checkOutput("clr_idle_flags", flags_q, 8'h00);
        model_flags = 8'h00;
        applyStimulus(0, 4'd8, 8'h01, 8'h02, 2'd0);
        issueOp(2'b01, 2'b00, 0, 1'b1);

        $display("[TB] reset during EXEC");
        applyStimulus(0, 4'd6, 8'h7F, 8'h01, 2'd2);
        req_valid = 2'b01;
        @(posedge clk); #1;
        checkOutput("rstx_exec_mode", alu_mode, 4'd6);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        checkOutput("rstx_resp_valid", resp_valid, 2'b00);
        checkOutput("rstx_flags_q", flags_q, 8'h00);
        checkOutput("rstx_alu_mode", alu_mode, 4'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstx_no_resp_later", resp_valid, 2'b00);
        checkOutput("rstx_flags_later", flags_q, 8'h00);
        model_flags = 8'h00;
        model_last  = 1'b0;
        applyStimulus(0, 4'd6, 8'h7F, 8'h01, 2'd2);
        applyStimulus(1, 4'd11, 8'hFF, 8'h0F, 2'd1);
        issueOp(2'b11, 2'b00, 0, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            logic [1:0] vm;
            for (int r = 0; r < 2; r++)
                applyStimulus(r, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
            vm = 2'($urandom_range(1, 3));
            issueOp(vm, vm, $urandom_range(0, 3), 1'b0);
        end
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
